fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage for the 5-stage pipeline: owns the PC, drives the instruction-memory read handshake, and owns the IF/ID pipeline register. It consumes the hazard unit's `stallF`, `stallD` and `flushD` outputs and turns them into PC holds, IF/ID holds, bubbles and branch redirects. It also absorbs multi-cycle instruction-memory latency and halts fetch on a HALT instruction.

## Interface
Parameters:
- `ADDR_W`, 16: PC/address width.
- `INSTR_W`, 16: instruction width.
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `NOP_INSTR`, 16'h0000: value driven on `instrD` when the IF/ID register is invalid.
- `HALT_OPCODE`, 4'hF: opcode in `instr[15:12]` that halts fetch.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stallF`  in  1  hold PC and the outstanding request.
- `stallD`  in  1  hold IF/ID.
- `flushD`  in  1  branch taken in D; redirect to `branch_target`.
- `branch_target`  in  ADDR_W  redirect address; sampled only when `flushD` is accepted.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  ADDR_W  read address; stable while `imem_req` is high and `imem_rdy` is low.
- `imem_rdy`  in  1  `imem_data` is valid this cycle for `imem_addr`.
- `imem_data`  in  INSTR_W  returned instruction.
- `instrD`  out  INSTR_W  IF/ID instruction.
- `pc_plus2D`  out  ADDR_W  IF/ID PC+2.
- `validD`  out  1  IF/ID holds a real instruction.
- `fetch_busy`  out  1  `imem_req & ~imem_rdy`; memory miss indicator for pipeline stall.
- `halt`  out  1  sticky; a HALT instruction has been accepted into D.

## Operation
- FSM states:
  - IDLE: reset state; `imem_req`=0; always moves to FETCH on the next edge.
  - FETCH: `imem_req`=1 with `imem_addr`=PC.
  - DRAIN: `imem_req`=1 with `imem_addr`=old PC; a redirect is pending in `redirect_pc`.
  - HALTED: `imem_req`=0; exit only via `rst`.
- Accepted flush: `flush_ok = flushD & validD & ~stallD`. `flushD` is ignored while `stallD`=1 (the branch operand is not ready) or while `validD`=0.
- FETCH cycle, evaluated in priority order:
  - `flush_ok` with `imem_rdy`=1: discard the response; PC <= `branch_target`; IF/ID <= bubble; stay in FETCH.
  - `flush_ok` with `imem_rdy`=0: `redirect_pc` <= `branch_target`; IF/ID <= bubble; go to DRAIN.
  - `imem_rdy & stallF`: discard the response; keep the request (it is re-read; reads are idempotent); PC holds.
  - `imem_rdy & ~stallF`: PC <= PC+2 (modulo 2^ADDR_W wrap). If `stallD`=0, IF/ID <= {`imem_data`, PC+2, valid=1}. If `imem_data[15:12]`==`HALT_OPCODE`, go to HALTED and set `halt`.
  - `imem_rdy`=0: everything holds.
- DRAIN: wait for `imem_rdy`, discard that response, PC <= `redirect_pc`, go to FETCH. IF/ID stays a bubble.
- IF/ID: holds when `stallD`=1. Becomes a bubble (`instrD`=`NOP_INSTR`, `validD`=0) on `flush_ok`, or when the PC advances without a response being loaded.
- HALTED: IF/ID still honours `stallD`/`flush_ok`. `halt` stays 1 until `rst`.
- `rst` mid-transaction: the outstanding request is abandoned. The memory must tolerate `imem_req` dropping.

## Timing
- Reset values: state=IDLE, PC=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `instrD`=`NOP_INSTR`, `pc_plus2D`=0, `validD`=0, `halt`=0, `fetch_busy`=0.
- Zero-wait memory (`imem_rdy` same cycle as request): one instruction per cycle. The instruction fetched in cycle N is visible on `instrD` in cycle N+1.
- Branch penalty: one bubble with zero-wait memory; one bubble plus the remaining miss latency when a request is outstanding.
- `imem_req`, `imem_addr` and `fetch_busy` are combinational from registered state, plus `imem_rdy` for `fetch_busy`.

## Structure
- `fetch_pkg` holds the state enum (IDLE, FETCH, DRAIN, HALTED), `NOP_INSTR` and `HALT_OPCODE` defaults.
- One sub-module, `if_id_reg`: the IF/ID register with load, hold and bubble controls. The FSM and PC stay in `fetch_unit`.

## Test plan
- Reset, then hold `imem_rdy`=1 with `imem_data`=addr|16'h1000:
  - `imem_req` first high in cycle 1 after `rst` falls.
  - `instrD`=16'h1000/16'h1002/16'h1004 on consecutive cycles from cycle 2, with `validD`=1 and `pc_plus2D`=0x0002/0x0004/0x0006.
- Assert `stallF`=`stallD`=1 for 2 cycles while `imem_addr`=0x0006: `imem_addr` holds 0x0006 and `instrD` holds 16'h1004 for 2 cycles, then the sequence resumes with 16'h1006.
- `flushD`=1, `branch_target`=0x0040, `imem_rdy`=1: next cycle `validD`=0, `instrD`=16'h0000, `imem_addr`=0x0040; the cycle after, `instrD`=16'h1040.
- 3-cycle memory latency, `flushD` on the first wait cycle at address 0x0008: the response for 0x0008 is never loaded into IF/ID; `imem_addr`=0x0040 the cycle after `imem_rdy`.
- `flushD`=1 and `stallD`=1 together: PC, IF/ID and `imem_addr` are unchanged and no redirect occurs.
- 16'hF000 returned at 0x000A:
  - next cycle `halt`=1, `imem_req`=0, and both stay so for 10 cycles.
  - `rst` then returns `imem_addr` to 0x0000 with `halt`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR_DEFAULT   = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: hold has priority over bubble, bubble over load.
module if_id_reg #(
  parameter int unsigned          ADDR_W    = 16,
  parameter int unsigned          INSTR_W   = 16,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               bubble,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_plus2_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus2,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      pc_plus2 <= '0;
      valid    <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end else if (load) begin
        instr    <= instr_in;
        pc_plus2 <= pc_plus2_in;
        valid    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory handshake, redirects, halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 16,
  parameter int unsigned        INSTR_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(NOP_INSTR_DEFAULT),
  parameter logic [3:0]         HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallF,
  input  logic               stallD,
  input  logic               flushD,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rdy,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instrD,
  output logic [ADDR_W-1:0]  pc_plus2D,
  output logic               validD,
  output logic               fetch_busy,
  output logic               halt
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, pc_inc;
  logic [ADDR_W-1:0] redirect_pc, redirect_next;
  logic              halt_next;
  logic              flush_ok, load, bubble;

  assign flush_ok   = flushD & validD & ~stallD;
  assign pc_inc     = pc + ADDR_W'(2);
  assign fetch_busy = imem_req & ~imem_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      halt        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_next;
      halt        <= halt_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    redirect_next = redirect_pc;
    halt_next     = halt;
    load          = 1'b0;
    bubble        = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = pc;
    unique case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (flush_ok) begin
          bubble = 1'b1;
          if (imem_rdy) begin
            pc_next = branch_target;
          end else begin
            redirect_next = branch_target;
            state_next    = DRAIN;
          end
        end else if (imem_rdy && !stallF) begin
          pc_next = pc_inc;
          load    = ~stallD;
          if (imem_data[INSTR_W-1 -: 4] == HALT_OPCODE) begin
            state_next = HALTED;
            halt_next  = 1'b1;
          end
        end
      end
      // The outstanding read must complete before the redirect can be issued.
      DRAIN: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          pc_next    = redirect_pc;
          bubble     = 1'b1;
          state_next = FETCH;
        end
      end
      HALTED: bubble = flush_ok;
    endcase
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .hold       (stallD),
    .bubble     (bubble),
    .load       (load),
    .instr_in   (imem_data),
    .pc_plus2_in(pc_inc),
    .instr      (instrD),
    .pc_plus2   (pc_plus2D),
    .valid      (validD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
  logic [15:0] branch_target = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data;
  logic [15:0] instrD;
  logic [15:0] pc_plus2D;
  logic        validD;
  logic        fetch_busy;
  logic        halt;

  logic [15:0] halt_addr = 16'hFFFF;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == halt_addr) ? 16'hF000 : (a | 16'h1000);
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_unit #(
    .ADDR_W     (16),
    .INSTR_W    (16),
    .RESET_PC   (16'h0000),
    .NOP_INSTR  (16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallF       (stallF),
    .stallD       (stallD),
    .flushD       (flushD),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdy     (imem_rdy),
    .imem_data    (imem_data),
    .instrD       (instrD),
    .pc_plus2D    (pc_plus2D),
    .validD       (validD),
    .fetch_busy   (fetch_busy),
    .halt         (halt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the stage has fetched, where it points, and what sits in D.
  bit          model_ok = 0;
  bit          m_started, m_halted, m_halt, m_valid;
  logic [15:0] m_pc, m_instr, m_pc2;
  logic [15:0] m_redir[$];

  task automatic model_step();
    bit          fok, bub;
    logic [15:0] w;
    if (rst) begin
      model_ok  = 1;
      m_started = 0; m_halted = 0; m_halt = 0;
      m_pc = 16'h0000; m_redir.delete();
      m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 0;
      return;
    end
    if (!model_ok) return;
    fok = flushD && m_valid && !stallD;
    bub = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (m_halted) begin
      bub = fok;
    end else if (m_redir.size() != 0) begin
      if (imem_rdy) m_pc = m_redir.pop_front();
    end else if (fok) begin
      bub = 1;
      if (imem_rdy) m_pc = branch_target;
      else m_redir.push_back(branch_target);
    end else if (imem_rdy && !stallF) begin
      w = mem_word(m_pc);
      if (!stallD) begin
        m_instr = w; m_pc2 = m_pc + 16'd2; m_valid = 1;
      end
      m_pc = m_pc + 16'd2;
      if (w[15:12] == 4'hF) begin m_halted = 1; m_halt = 1; end
    end
    if (bub && !stallD) begin m_instr = 16'h0000; m_valid = 0; end
  endtask

  initial begin
    bit exp_req;
    forever begin
      @(negedge clk);
      if (model_ok) begin
        exp_req = m_started && !m_halted;
        check("imem_req", imem_req, exp_req);
        check("imem_addr", imem_addr, m_pc);
        check("fetch_busy", fetch_busy, exp_req && !imem_rdy);
        check("instrD", instrD, m_instr);
        check("pc_plus2D", pc_plus2D, m_pc2);
        check("validD", validD, m_valid);
        check("halt", halt, m_halt);
      end
      model_step();
    end
  end

  task automatic drive(input logic r, sf, sd, fl, rd, input logic [15:0] bt);
    @(posedge clk);
    #1;
    rst = r; stallF = sf; stallD = sd; flushD = fl; imem_rdy = rd; branch_target = bt;
    #1;
  endtask

  initial begin
    int unsigned halted_cycles;
    drive(1, 0, 0, 0, 0, 16'h0000);
    drive(1, 0, 0, 0, 0, 16'h0000);
    // cycle 0: IDLE after reset
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c0 req", imem_req, 0);
    check("c0 addr", imem_addr, 16'h0000);
    check("c0 instrD", instrD, 16'h0000);
    check("c0 pc2", pc_plus2D, 16'h0000);
    check("c0 valid", validD, 0);
    check("c0 halt", halt, 0);
    check("c0 busy", fetch_busy, 0);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c1 req", imem_req, 1);
    check("c1 addr", imem_addr, 16'h0000);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c2 instrD", instrD, 16'h1000);
    check("c2 valid", validD, 1);
    check("c2 pc2", pc_plus2D, 16'h0002);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c3 instrD", instrD, 16'h1002);
    check("c3 pc2", pc_plus2D, 16'h0004);
    drive(0, 1, 1, 0, 1, 16'h0000);
    check("c4 instrD", instrD, 16'h1004);
    check("c4 pc2", pc_plus2D, 16'h0006);
    check("c4 addr", imem_addr, 16'h0006);
    drive(0, 1, 1, 0, 1, 16'h0000);
    check("c5 addr", imem_addr, 16'h0006);
    check("c5 instrD", instrD, 16'h1004);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c6 addr", imem_addr, 16'h0006);
    check("c6 instrD", instrD, 16'h1004);
    drive(0, 0, 0, 1, 1, 16'h0040);
    check("c7 instrD", instrD, 16'h1006);
    check("c7 valid", validD, 1);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c8 valid", validD, 0);
    check("c8 instrD", instrD, 16'h0000);
    check("c8 addr", imem_addr, 16'h0040);
    drive(0, 0, 0, 1, 1, 16'h0006);
    check("c9 instrD", instrD, 16'h1040);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c10 valid", validD, 0);
    check("c10 addr", imem_addr, 16'h0006);
    // flush on the first wait cycle of a 3-cycle read of 0x0008
    drive(0, 0, 0, 1, 0, 16'h0040);
    check("c11 instrD", instrD, 16'h1006);
    check("c11 addr", imem_addr, 16'h0008);
    check("c11 busy", fetch_busy, 1);
    drive(0, 0, 0, 0, 0, 16'h0000);
    check("c12 valid", validD, 0);
    check("c12 addr", imem_addr, 16'h0008);
    check("c12 busy", fetch_busy, 1);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c13 valid", validD, 0);
    check("c13 busy", fetch_busy, 0);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c14 addr", imem_addr, 16'h0040);
    check("c14 valid", validD, 0);
    drive(0, 1, 1, 1, 1, 16'h0080);
    check("c15 instrD", instrD, 16'h1040);
    check("c15 addr", imem_addr, 16'h0042);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c16 addr", imem_addr, 16'h0042);
    check("c16 instrD", instrD, 16'h1040);
    check("c16 valid", validD, 1);
    halt_addr = 16'h000A;
    drive(0, 0, 0, 1, 1, 16'h000A);
    check("c17 instrD", instrD, 16'h1042);
    check("c17 addr", imem_addr, 16'h0044);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("c18 addr", imem_addr, 16'h000A);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, 16'h0000);
      check("halted halt", halt, 1);
      check("halted req", imem_req, 0);
    end
    check("halted instrD", instrD, 16'hF000);
    drive(1, 0, 0, 0, 1, 16'h0000);
    drive(0, 0, 0, 0, 1, 16'h0000);
    check("post-rst addr", imem_addr, 16'h0000);
    check("post-rst halt", halt, 0);
    check("post-rst req", imem_req, 0);

    // randomized traffic
    halt_addr = 16'($urandom_range(0, 16'h07FF)) & 16'hFFFE;
    halted_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r;
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      r = ($urandom_range(0, 199) < 3) || (halted_cycles > 6);
      drive(r, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
            16'($urandom_range(0, 16'h07FF)) & 16'hFFFE);
      if (r) halt_addr = 16'($urandom_range(0, 16'h07FF)) & 16'hFFFE;
    end
    drive(0, 0, 0, 0, 1, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
